cache_axi_rd_arbiter: RTL and testbench
=======================================

# cache_axi_rd_arbiter

Read-side arbiter and burst sequencer that shares the single AXI read channel among the four cache-side read requesters: DCache refill, uncached data read, ICache refill and uncached inst read. It grants one requester at a time and issues one AXI read (an 8-beat line burst or a single beat). It assembles the returned beats into a line buffer and returns the result to the granted requester with a one-cycle valid pulse. It sits between the ICache/DCache/uncached paths and the AXI master, and replaces the read portion of the cache-AXI interface.

## Interface
- LINE_WORDS, 8, words per cache line; power of two, at most 16.
- ADDR_W, 32, address width.
- DATA_W, 32, AXI data width (one word).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rd_req_i  in  4  request vector; bit0 DCache refill, bit1 uncached data, bit2 ICache refill, bit3 uncached inst.
- rd_addr_i  in  4*ADDR_W  physical addresses; slice k belongs to requester k.
- flush_i  in  1  pipeline flush; cancels delivery to inst requesters (bits 2, 3).
- rd_valid_o  out  4  one-hot, single-cycle result-valid pulse to the granted requester.
- rd_data_o  out  LINE_WORDS*DATA_W  line buffer; for a single-beat read the word is in [DATA_W-1:0].
- busy_o  out  1  high whenever the FSM is not in IDLE.
- axi_ren_o  out  1  read-address valid.
- axi_arready_i  in  1  read address accepted.
- axi_raddr_o  out  ADDR_W  read address.
- axi_rlen_o  out  4  burst length minus 1.
- axi_rready_o  out  1  ready for read data.
- axi_rvalid_i  in  1  read beat valid.
- axi_rdata_i  in  DATA_W  read beat data.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - If any unmasked bit of rd_req_i is set, latch the one-hot grant, address and length, then go to ADDR.
  - Otherwise stay in IDLE.
- **Arbitration** happens between two groups: the data group (bits 0, 1) and the inst group (bits 2, 3).
  - The group that did not win the previous grant has priority when both groups request.
  - Within a group, refill beats uncached (bit0 over bit1, bit2 over bit3).
  - The last-winner register resets to "inst", so data wins the first contention.
- **Address and length per request type**
  - Refill (bits 0, 2): address = rd_addr_i slice with the low log2(LINE_WORDS*4) bits cleared; rlen = LINE_WORDS-1.
  - Uncached (bits 1, 3): address passed unmodified; rlen = 0.
- **ADDR**
  - axi_ren_o=1; axi_raddr_o and axi_rlen_o are held stable.
  - On axi_arready_i, clear the beat counter and go to DATA.
- **DATA**
  - axi_rready_o=1.
  - Each cycle with axi_rvalid_i, write axi_rdata_i into word[cnt] and increment cnt.
  - The beat where cnt==rlen is the last beat; go to RESP after it.
  - There is no rlast input; completion is decided only by the beat count.
- **RESP**
  - rd_valid_o[grant]=1 for exactly one cycle, then return to IDLE.
  - rd_data_o holds the buffer contents until the next DATA beat overwrites them.
- **Request handshake**
  - A requester holds req and addr stable until it sees its valid pulse.
  - It drops req combinationally in the valid cycle (req & ~valid).
  - The arbiter ignores rd_req_i while in RESP.
- **Flush**
  - If flush_i is high in any cycle while the grant is an inst requester (ADDR, DATA or RESP), set a drop flag.
  - The AXI transaction always runs to completion; it is never abandoned mid-burst.
  - In RESP with drop set, rd_valid_o stays 0. Drop clears on entry to IDLE.
  - In IDLE, flush_i masks bits 2 and 3 for that cycle.
  - Flush has no effect on data-group grants.
- **Reset (rst=0), at any time including mid-burst**
  - State returns to IDLE; grant, drop, cnt and the line buffer clear to 0.
  - All outputs are 0: rd_valid_o, rd_data_o, busy_o, axi_ren_o, axi_raddr_o, axi_rlen_o, axi_rready_o.
  - The AXI slave must be reset by the same signal.

## Timing
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Request at cycle t in IDLE gives axi_ren_o at t+1.
- If axi_arready_i is already high, DATA starts at t+2.
- Last beat at cycle u gives rd_valid_o at u+1. The next grant can be latched at u+2, which is the earliest next axi_ren_o at u+3.
- Minimum latency, uncached with zero-wait slave: request t, valid t+4.
- Minimum latency, refill with zero-wait slave: request t, valid t+3+LINE_WORDS.
- Gaps in axi_rvalid_i stall cnt; a beat is accepted only when rvalid is high.

## Test plan
- **Single refill:** req=0001, addr=0x1FC0_0014, zero-wait slave returning 0xA0..0xA7.
  - axi_raddr_o=0x1FC0_0000, rlen=7.
  - rd_valid_o=0001 exactly one cycle, 11 cycles after the request.
  - word[i]=0xA0+i.
- **Contention:** req=0101 held; first grant is data, then ICache.
  - Raise bit0 again during the ICache burst.
  - Next grant is data (alternation holds); no requester waits for more than one other transaction.
- **Uncached inst:** req=1000, addr=0xBFC0_0004, rdata=0x2402_0001.
  - rlen=0, address unaligned and unchanged.
  - rd_data_o[31:0]=0x2402_0001; valid=1000 at t+4.
- **Flush mid-burst:** ICache refill granted, flush_i pulsed during beat 3.
  - All 8 beats are still accepted.
  - rd_valid_o stays 0; the FSM returns to IDLE and accepts a following data request.
- **Backpressure:** refill with rvalid low on alternate cycles and arready delayed 3 cycles.
  - ren is held with a stable address for the 3 cycles.
  - Exactly 8 beats captured in order; valid follows the last beat by one cycle.
- **Reset mid-burst:** assert rst=0 after beat 4.
  - All outputs read 0 immediately (asynchronous reset).
  - After release, a new uncached data request completes normally with no stale valid pulse.

Source files
------------

// File: rtl/cache_axi_rd_arbiter_if.sv
// Read-side bundle shared by the cache requesters, the read arbiter and the AXI read port.
// The master modport is the arbiter's view; the slave modport is the view of the
// surrounding requesters and AXI slave that drive the arbiter's inputs.
interface cache_axi_rd_arbiter_if #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic [3:0]                   rd_req_i;
  logic [4*ADDR_W-1:0]          rd_addr_i;
  logic                         flush_i;
  logic [3:0]                   rd_valid_o;
  logic [LINE_WORDS*DATA_W-1:0] rd_data_o;
  logic                         busy_o;
  logic                         axi_ren_o;
  logic                         axi_arready_i;
  logic [ADDR_W-1:0]            axi_raddr_o;
  logic [3:0]                   axi_rlen_o;
  logic                         axi_rready_o;
  logic                         axi_rvalid_i;
  logic [DATA_W-1:0]            axi_rdata_i;

  modport master (
    input  rd_req_i, rd_addr_i, flush_i, axi_arready_i, axi_rvalid_i, axi_rdata_i,
    output rd_valid_o, rd_data_o, busy_o, axi_ren_o, axi_raddr_o, axi_rlen_o, axi_rready_o
  );

  modport slave (
    output rd_req_i, rd_addr_i, flush_i, axi_arready_i, axi_rvalid_i, axi_rdata_i,
    input  rd_valid_o, rd_data_o, busy_o, axi_ren_o, axi_raddr_o, axi_rlen_o, axi_rready_o
  );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read channel among DCache refill, uncached data, ICache refill and
// uncached inst reads. One transaction at a time: grant, issue the read, collect the
// beats into a line buffer, then pulse valid to the winner (unless flushed).
module cache_axi_rd_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input logic clk,
  input logic rst,
  cache_axi_rd_arbiter_if.master bus
);

  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [3:0] REFILL_LEN = 4'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state, next_state;

  logic [3:0]                        grant;
  logic [ADDR_W-1:0]                 addr_q;
  logic [3:0]                        rlen_q;
  logic [3:0]                        cnt;
  logic                              drop;
  logic                              last_inst;
  logic [LINE_WORDS-1:0][DATA_W-1:0] line_buf;

  logic [3:0]        req_masked;
  logic [3:0]        pick;
  logic              data_any;
  logic              inst_any;
  logic              take_inst;
  logic [ADDR_W-1:0] pick_addr;
  logic [3:0]        pick_len;

  // Group round-robin between data and inst, fixed refill-first priority inside a group.
  always_comb begin
    req_masked = bus.rd_req_i & ~(bus.flush_i ? 4'b1100 : 4'b0000);
    data_any   = |req_masked[1:0];
    inst_any   = |req_masked[3:2];
    take_inst  = inst_any && (!data_any || !last_inst);
    pick       = 4'b0000;
    if (take_inst) begin
      pick = req_masked[2] ? 4'b0100 : 4'b1000;
    end else if (data_any) begin
      pick = req_masked[0] ? 4'b0001 : 4'b0010;
    end
    pick_addr = '0;
    pick_len  = 4'd0;
    case (pick)
      4'b0001: begin
        pick_addr = bus.rd_addr_i[0 +: ADDR_W] & LINE_MASK;
        pick_len  = REFILL_LEN;
      end
      4'b0010: pick_addr = bus.rd_addr_i[ADDR_W +: ADDR_W];
      4'b0100: begin
        pick_addr = bus.rd_addr_i[2*ADDR_W +: ADDR_W] & LINE_MASK;
        pick_len  = REFILL_LEN;
      end
      4'b1000: pick_addr = bus.rd_addr_i[3*ADDR_W +: ADDR_W];
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: completion is decided purely by the beat count, there is no rlast.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (|pick) next_state = ADDR;
      ADDR: if (bus.axi_arready_i) next_state = DATA;
      DATA: if (bus.axi_rvalid_i && (cnt == rlen_q)) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant/address capture, beat collection and the flush drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= 4'b0000;
      addr_q    <= '0;
      rlen_q    <= 4'd0;
      cnt       <= 4'd0;
      drop      <= 1'b0;
      last_inst <= 1'b1;
      line_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick) begin
            grant     <= pick;
            addr_q    <= pick_addr;
            rlen_q    <= pick_len;
            last_inst <= |pick[3:2];
          end
        end
        ADDR: begin
          if (bus.axi_arready_i) cnt <= 4'd0;
          if (bus.flush_i && (|grant[3:2])) drop <= 1'b1;
        end
        DATA: begin
          if (bus.axi_rvalid_i) begin
            line_buf[cnt[IDX_W-1:0]] <= bus.axi_rdata_i;
            cnt                      <= cnt + 4'd1;
          end
          if (bus.flush_i && (|grant[3:2])) drop <= 1'b1;
        end
        // A flush seen in RESP cannot retract the pulse already decoded this cycle.
        RESP: drop <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    bus.rd_valid_o   = ((state == RESP) && !drop) ? grant : 4'b0000;
    bus.rd_data_o    = line_buf;
    bus.busy_o       = (state != IDLE);
    bus.axi_ren_o    = (state == ADDR);
    bus.axi_raddr_o  = addr_q;
    bus.axi_rlen_o   = rlen_q;
    bus.axi_rready_o = (state == DATA);
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Bench for cache_axi_rd_arbiter: requester and AXI slave models driven cycle by cycle,
// with a scoreboard of expected grants, addresses, lengths and line contents.
module tb_cache_axi_rd_arbiter;

  localparam int LINE_WORDS = 8;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;

  logic clk = 1'b0;
  logic rst;

  cache_axi_rd_arbiter_if #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  cache_axi_rd_arbiter #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  grant;
    logic [31:0] addr;
    logic [3:0]  rlen;
    logic [31:0] base;
    bit          deliver;
    int          lat;
  } exp_t;

  typedef struct {
    int          k;
    logic [31:0] addr;
    bit          flush_first;
    logic [31:0] exp_addr;
    logic [3:0]  exp_rlen;
    logic [31:0] base;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[7];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  bit resp_due = 0;
  int req_cycle[4];

  int ar_delay = 0;
  int ar_wait = 0;
  bit gap_en = 0;
  bit gap_phase = 0;
  bit in_burst = 0;
  bit first_wait = 0;
  int beats_left = 0;
  int beats_sent = 0;
  int ar_count = 0;
  int last_beat_cycle = 0;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic apply_stimulus(input int k, input logic [31:0] a, input logic [31:0] exp_addr,
                                input logic [3:0] exp_rlen, input logic [31:0] base,
                                input bit deliver, input int lat);
    exp_t e;
    bus.rd_req_i[k]            = 1'b1;
    bus.rd_addr_i[k*32 +: 32]  = a;
    req_cycle[k]               = cycle;
    e.grant   = 4'b0001 << k;
    e.addr    = exp_addr;
    e.rlen    = exp_rlen;
    e.base    = base;
    e.deliver = deliver;
    e.lat     = lat;
    exp_q.push_back(e);
  endtask

  task automatic monitor_valid();
    int gi;
    logic [255:0] ed;
    if (bus.rd_valid_o != 4'b0000) begin
      if (resp_due) begin
        gi = 0;
        for (int i = 0; i < 4; i++) if (cur.grant[i]) gi = i;
        check_output("grant", 256'(bus.rd_valid_o), 256'(cur.grant));
        check_output("beat_count", 256'(beats_sent), 256'(cur.rlen) + 256'd1);
        check_output("valid_after_last_beat", 256'(cycle - last_beat_cycle), 256'd1);
        if (cur.lat != 0)
          check_output("latency", 256'(cycle - req_cycle[gi]), 256'(cur.lat));
        if (cur.rlen == 4'd0) begin
          check_output("single_word", 256'(bus.rd_data_o[31:0]), 256'(cur.base));
        end else begin
          ed = '0;
          for (int i = 0; i < LINE_WORDS; i++) ed[i*32 +: 32] = cur.base + 32'(i);
          check_output("line_data", bus.rd_data_o, ed);
        end
        resp_due = 0;
      end else begin
        check_output("spurious_valid", 256'(bus.rd_valid_o), 256'd0);
      end
      bus.rd_req_i = bus.rd_req_i & ~bus.rd_valid_o;
    end
  endtask

  task automatic drive_slave();
    if (bus.axi_ren_o) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_ar", 256'(bus.axi_ren_o), 256'd0);
        bus.axi_arready_i = 1'b0;
      end else begin
        check_output("raddr_stable", 256'(bus.axi_raddr_o), 256'(exp_q[0].addr));
        if (ar_wait >= ar_delay) begin
          bus.axi_arready_i = 1'b1;
          cur = exp_q.pop_front();
          check_output("rlen", 256'(bus.axi_rlen_o), 256'(cur.rlen));
          in_burst   = 1;
          first_wait = 1;
          beats_left = int'(cur.rlen) + 1;
          beats_sent = 0;
          resp_due   = cur.deliver;
          gap_phase  = 0;
          ar_wait    = 0;
          ar_count++;
        end else begin
          bus.axi_arready_i = 1'b0;
          ar_wait++;
        end
      end
    end else begin
      bus.axi_arready_i = 1'b0;
      ar_wait = 0;
    end
    bus.axi_rvalid_i = 1'b0;
    bus.axi_rdata_i  = '0;
    if (bus.axi_rready_o && in_burst) begin
      if (first_wait) begin
        first_wait = 0;
      end else if (gap_en && gap_phase) begin
        gap_phase = 0;
      end else begin
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rdata_i  = cur.base + 32'(beats_sent);
        gap_phase        = gap_en;
        beats_sent++;
        beats_left--;
        last_beat_cycle  = cycle;
        if (beats_left == 0) in_burst = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle++;
    monitor_valid();
    drive_slave();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((bus.busy_o || resp_due || bus.rd_req_i != 4'b0000 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_output({name, "_done"},
                 256'(bus.busy_o || resp_due || bus.rd_req_i != 4'b0000 || exp_q.size() != 0), 256'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, 256'(bus.rd_valid_o), 256'd0);
    check_output({tag, "_data"}, bus.rd_data_o, 256'd0);
    check_output({tag, "_busy"}, 256'(bus.busy_o), 256'd0);
    check_output({tag, "_ren"}, 256'(bus.axi_ren_o), 256'd0);
    check_output({tag, "_raddr"}, 256'(bus.axi_raddr_o), 256'd0);
    check_output({tag, "_rlen"}, 256'(bus.axi_rlen_o), 256'd0);
    check_output({tag, "_rready"}, 256'(bus.axi_rready_o), 256'd0);
  endtask

  task automatic clear_models();
    exp_q.delete();
    resp_due          = 0;
    in_burst          = 0;
    first_wait        = 0;
    ar_wait           = 0;
    bus.rd_req_i      = 4'b0000;
    bus.flush_i       = 1'b0;
    bus.axi_arready_i = 1'b0;
    bus.axi_rvalid_i  = 1'b0;
    bus.axi_rdata_i   = '0;
  endtask

  // Main sequence: reset, contention, table of single transactions, then corner cases.
  initial begin
    int n;
    int ar_start;
    vecs[0] = '{0, 32'h1FC0_0014, 1'b0, 32'h1FC0_0000, 4'd7, 32'h0000_00A0, 11};
    vecs[1] = '{1, 32'h8000_1236, 1'b0, 32'h8000_1236, 4'd0, 32'h5555_AAAA, 4};
    vecs[2] = '{2, 32'h0040_003C, 1'b0, 32'h0040_0020, 4'd7, 32'h0000_0100, 11};
    vecs[3] = '{3, 32'hBFC0_0004, 1'b0, 32'hBFC0_0004, 4'd0, 32'h2402_0001, 4};
    vecs[4] = '{2, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFE0, 4'd7, 32'h0000_0200, 12};
    vecs[5] = '{0, 32'h0000_001F, 1'b1, 32'h0000_0000, 4'd7, 32'h0000_0300, 11};
    vecs[6] = '{3, 32'h0000_0003, 1'b1, 32'h0000_0003, 4'd0, 32'h0000_0400, 5};

    rst           = 1'b0;
    bus.rd_addr_i = '0;
    clear_models();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    step();

    // Contention: data wins first after reset, then groups alternate.
    ar_start = ar_count;
    apply_stimulus(0, 32'h0000_1004, 32'h0000_1000, 4'd7, 32'h0000_1000, 1'b1, 0);
    apply_stimulus(2, 32'h0000_2040, 32'h0000_2040, 4'd7, 32'h0000_2000, 1'b1, 0);
    n = 0;
    while (ar_count < ar_start + 2 && n < 60) begin step(); n++; end
    check_output("icache_granted", 256'(ar_count - ar_start), 256'd2);
    step();
    apply_stimulus(0, 32'h0000_3010, 32'h0000_3000, 4'd7, 32'h0000_3000, 1'b1, 0);
    apply_stimulus(3, 32'hBFC0_0100, 32'hBFC0_0100, 4'd0, 32'h0000_5000, 1'b1, 0);
    wait_idle("contention", 120);

    // Table of isolated transactions, some with flush in the request cycle.
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].k, vecs[v].addr, vecs[v].exp_addr, vecs[v].exp_rlen,
                     vecs[v].base, 1'b1, vecs[v].lat);
      bus.flush_i = vecs[v].flush_first;
      step();
      bus.flush_i = 1'b0;
      wait_idle("vector", 40);
    end

    // Flush during beat 3 of an ICache refill: burst completes, no valid.
    apply_stimulus(2, 32'h0040_8010, 32'h0040_8000, 4'd7, 32'h0000_0600, 1'b0, 0);
    n = 0;
    while (!(in_burst && beats_sent == 3) && n < 40) begin step(); n++; end
    check_output("flush_reached_beat3", 256'(beats_sent), 256'd3);
    bus.flush_i     = 1'b1;
    bus.rd_req_i[2] = 1'b0;
    step();
    bus.flush_i = 1'b0;
    wait_idle("flush", 40);
    check_output("flush_beats", 256'(beats_sent), 256'd8);
    check_output("flush_last_word", 256'(bus.rd_data_o[255:224]), 256'h607);
    apply_stimulus(1, 32'h1234_5678, 32'h1234_5678, 4'd0, 32'h0000_0700, 1'b1, 4);
    wait_idle("after_flush", 40);

    // Flush held through a data refill has no effect.
    apply_stimulus(0, 32'h0000_2224, 32'h0000_2220, 4'd7, 32'h0000_0800, 1'b1, 11);
    bus.flush_i = 1'b1;
    wait_idle("data_flush", 40);
    bus.flush_i = 1'b0;

    // Backpressure: arready delayed 3 cycles, rvalid on alternate cycles.
    ar_delay = 3;
    gap_en   = 1;
    apply_stimulus(0, 32'h4000_0048, 32'h4000_0040, 4'd7, 32'h0000_0900, 1'b1, 0);
    wait_idle("backpressure", 80);
    ar_delay = 0;
    gap_en   = 0;

    // Reset mid-burst after beat 4, then a clean uncached data read.
    apply_stimulus(0, 32'h0000_5000, 32'h0000_5000, 4'd7, 32'h0000_0A00, 1'b1, 0);
    n = 0;
    while (!(in_burst && beats_sent == 4) && n < 40) begin step(); n++; end
    check_output("reached_beat4", 256'(beats_sent), 256'd4);
    step();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    clear_models();
    step();
    step();
    rst = 1'b1;
    apply_stimulus(1, 32'h0000_7778, 32'h0000_7778, 4'd0, 32'h0000_0B00, 1'b1, 4);
    wait_idle("post_reset", 40);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
